apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_wait_cnt.sv | 43 ++++
 rtl/apb_cmd_master.sv | 163 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: FSM state encoding and the
// default transfer timeout.
package apb_pkg;

    // Transfer phases of the APB master.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apbState_t;

    // Default number of ACCESS cycles allowed before a transfer is aborted.
    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_wait_cnt.sv
// Wait-state counter for the ACCESS phase. It counts cycles in which the
// slave holds PREADY low, saturates instead of wrapping, and flags when the
// last permitted wait cycle has been reached.
module apb_wait_cnt
    import apb_pkg::*;
#(
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise step up until the saturation value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_W'(TIMEOUT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous reset to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// APB master driven by a simple valid/ready command port. Each accepted
// command becomes one APB transfer (SETUP then ACCESS); completion or a
// wait-state timeout is reported with a one-cycle rsp_valid pulse.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    // Command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    // Response side
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    // APB master side
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // A timeout below 2 leaves no room for a single wait state.
    if (TIMEOUT < 2) begin : gBadTimeout
        $error("apb_cmd_master: TIMEOUT must be at least 2");
    end

    apbState_t         state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic              rspValid_q, rspValid_d;
    logic [31:0]       rspRdata_q, rspRdata_d;
    logic              rspErr_q, rspErr_d;

    logic              waitClear;
    logic              waitEnable;
    logic [CNT_W-1:0]  waitCount;
    logic              waitExpired;
    logic              unusedWaitCount;

    // The counter restarts whenever we are outside ACCESS, so it is zero on
    // entry, and it only advances while the slave is stalling.
    assign waitClear  = (state_q != ACCESS);
    assign waitEnable = (state_q == ACCESS) && !PREADY;

    apb_wait_cnt #(
        .TIMEOUT (TIMEOUT)
    ) uWaitCnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (waitClear),
        .enable  (waitEnable),
        .count   (waitCount),
        .expired (waitExpired)
    );

    // The raw count is only of interest for debug; the FSM uses expired.
    assign unusedWaitCount = ^waitCount;

    // Next-state and next-output decode; PREADY completion has priority over
    // the timeout so a late but valid response is never reported as an error.
    always_comb begin
        state_d    = state_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        rspValid_d = 1'b0;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d    = IDLE;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    rspValid_d = 1'b1;
                    rspErr_d   = 1'b0;
                    rspRdata_d = pwrite_q ? 32'd0 : PRDATA;
                end else if (waitExpired) begin
                    state_d    = IDLE;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    rspValid_d = 1'b1;
                    rspErr_d   = 1'b1;
                    rspRdata_d = 32'd0;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= 32'd0;
            rspValid_q <= 1'b0;
            rspRdata_q <= 32'd0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed testbench for apb_cmd_master: write with one wait state, read,
// timeout, PREADY on the timeout cycle, back-to-back commands and reset
// during ACCESS. Inputs change and outputs are sampled on the falling edge.
module tb_apb_cmd_master;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;

    int errors = 0;
    int checks = 0;

    apb_cmd_master #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int accessCycles;

        reset  = 1'b1;
        PREADY = 1'b0;
        PRDATA = 32'd0;
        applyStimulus(1'b0, 1'b0, '0, 32'd0);
        step();
        step();

        // Reset state
        checkOutput("rst_psel",      32'(PSEL),      32'd0);
        checkOutput("rst_penable",   32'(PENABLE),   32'd0);
        checkOutput("rst_pwrite",    32'(PWRITE),    32'd0);
        checkOutput("rst_paddr",     32'(PADDR),     32'd0);
        checkOutput("rst_pwdata",    PWDATA,         32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata,      32'd0);
        checkOutput("rst_rsp_err",   32'(rsp_err),   32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        step();

        // Write 0xA5 to address 4, slave ready on the second ACCESS cycle
        applyStimulus(1'b1, 1'b1, 4'h4, 32'h0000_00A5);
        step();
        applyStimulus(1'b0, 1'b0, '0, 32'd0);
        checkOutput("wr_setup_psel",    32'(PSEL),      32'd1);
        checkOutput("wr_setup_penable", 32'(PENABLE),   32'd0);
        checkOutput("wr_setup_pwrite",  32'(PWRITE),    32'd1);
        checkOutput("wr_setup_paddr",   32'(PADDR),     32'h4);
        checkOutput("wr_setup_pwdata",  PWDATA,         32'hA5);
        checkOutput("wr_setup_ready",   32'(cmd_ready), 32'd0);
        step();
        checkOutput("wr_acc1_penable", 32'(PENABLE),   32'd1);
        checkOutput("wr_acc1_pwdata",  PWDATA,         32'hA5);
        step();
        checkOutput("wr_acc2_psel",    32'(PSEL),      32'd1);
        checkOutput("wr_acc2_penable", 32'(PENABLE),   32'd1);
        checkOutput("wr_acc2_pwdata",  PWDATA,         32'hA5);
        checkOutput("wr_acc2_valid",   32'(rsp_valid), 32'd0);
        PREADY = 1'b1;
        step();
        PREADY = 1'b0;
        checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wr_rsp_err",   32'(rsp_err),   32'd0);
        checkOutput("wr_rsp_rdata", rsp_rdata,      32'd0);
        checkOutput("wr_done_psel", 32'(PSEL),      32'd0);
        checkOutput("wr_done_pen",  32'(PENABLE),   32'd0);
        checkOutput("wr_done_rdy",  32'(cmd_ready), 32'd1);
        step();
        checkOutput("wr_pulse_end", 32'(rsp_valid), 32'd0);

        // PREADY while idle has no effect
        PREADY = 1'b1;
        step();
        step();
        PREADY = 1'b0;
        checkOutput("idle_pready_valid", 32'(rsp_valid), 32'd0);
        checkOutput("idle_pready_psel",  32'(PSEL),      32'd0);

        // Read address 0xC, slave answers on the first ACCESS cycle
        applyStimulus(1'b1, 1'b0, 4'hC, 32'hFFFF_FFFF);
        step();
        applyStimulus(1'b0, 1'b0, '0, 32'd0);
        checkOutput("rd_setup_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rd_setup_paddr", 32'(PADDR),     32'hC);
        checkOutput("rd_setup_write", 32'(PWRITE),    32'd0);
        step();
        checkOutput("rd_acc_ready",   32'(cmd_ready), 32'd0);
        checkOutput("rd_acc_penable", 32'(PENABLE),   32'd1);
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        step();
        PREADY = 1'b0;
        PRDATA = 32'd0;
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd_rsp_rdata", rsp_rdata,      32'h1234_5678);
        checkOutput("rd_rsp_err",   32'(rsp_err),   32'd0);
        checkOutput("rd_rsp_ready", 32'(cmd_ready), 32'd1);
        step();

        // Slave never answers: abort after TIMEOUT ACCESS cycles
        applyStimulus(1'b1, 1'b0, 4'h2, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, '0, 32'd0);
        accessCycles = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            if (PSEL && PENABLE) accessCycles++;
            step();
        end
        checkOutput("to_rsp_valid",     32'(rsp_valid), 32'd1);
        checkOutput("to_access_cycles", accessCycles,   32'd16);
        checkOutput("to_rsp_err",       32'(rsp_err),   32'd1);
        checkOutput("to_rsp_rdata",     rsp_rdata,      32'd0);
        checkOutput("to_psel_after",    32'(PSEL),      32'd0);
        step();

        // PREADY on the 16th ACCESS cycle beats the timeout
        applyStimulus(1'b1, 1'b0, 4'h3, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, '0, 32'd0);
        repeat (16) step();
        checkOutput("late_still_access", 32'(PENABLE),   32'd1);
        checkOutput("late_no_rsp_yet",   32'(rsp_valid), 32'd0);
        PREADY = 1'b1;
        PRDATA = 32'hCAFE_F00D;
        step();
        PREADY = 1'b0;
        PRDATA = 32'd0;
        checkOutput("late_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("late_rsp_err",   32'(rsp_err),   32'd0);
        checkOutput("late_rsp_rdata", rsp_rdata,      32'hCAFE_F00D);
        step();

        // Back-to-back writes with cmd_valid held and a zero-wait slave
        PREADY = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'h5, 32'h0000_0011);
        step();
        checkOutput("b2b_setup1_psel",   32'(PSEL),    32'd1);
        checkOutput("b2b_setup1_pwdata", PWDATA,       32'h11);
        applyStimulus(1'b1, 1'b1, 4'h6, 32'h0000_0022);
        step();
        checkOutput("b2b_acc1_penable", 32'(PENABLE), 32'd1);
        checkOutput("b2b_acc1_pwdata",  PWDATA,       32'h11);
        checkOutput("b2b_acc1_paddr",   32'(PADDR),   32'h5);
        step();
        checkOutput("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
        checkOutput("b2b_rsp1_ready", 32'(cmd_ready), 32'd1);
        checkOutput("b2b_rsp1_psel",  32'(PSEL),      32'd0);
        step();
        applyStimulus(1'b0, 1'b0, '0, 32'd0);
        checkOutput("b2b_setup2_psel",   32'(PSEL),    32'd1);
        checkOutput("b2b_setup2_pen",    32'(PENABLE), 32'd0);
        checkOutput("b2b_setup2_pwdata", PWDATA,       32'h22);
        checkOutput("b2b_setup2_paddr",  32'(PADDR),   32'h6);
        step();
        step();
        checkOutput("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
        PREADY = 1'b0;
        step();

        // Reset during ACCESS drops the bus at once and reports nothing
        applyStimulus(1'b1, 1'b0, 4'h7, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, '0, 32'd0);
        step();
        checkOutput("rst_mid_pre_psel", 32'(PSEL), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_psel",    32'(PSEL),    32'd0);
        checkOutput("rst_mid_penable", 32'(PENABLE), 32'd0);
        PREADY = 1'b1;
        step();
        checkOutput("rst_mid_no_valid", 32'(rsp_valid), 32'd0);
        reset  = 1'b0;
        PREADY = 1'b0;
        step();
        checkOutput("rst_rel_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_rel_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rel_psel",  32'(PSEL),      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
